// File: rtl/contador_verificador.sv
`default_nettype none
// ============================================================================
// Module      : contador_verificador
// Description : Checker/monitor for the 4-bit mode counter (up, down,
//               down-by-3, parallel load, registered RCO). Taps the counter's
//               stimulus and outputs, keeps a registered reference model,
//               compares every cycle once synchronised by a load, and reports
//               mismatch pulses, a sticky failure flag and saturating
//               error/check counters.
// Option      : CONTADOR_VERIF_RESYNC_EN - when defined, FAULT falls back to
//               UNSYNC on the next edge so checking resumes after a new load.
//               When undefined, FAULT is terminal until RESET.
// Revision    : 1.0 - initial release
// ============================================================================
module contador_verificador #(
    parameter int BITS  = 4,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENB,
    input  logic [1:0]       MODO,
    input  logic [BITS-1:0]  D,
    input  logic [BITS-1:0]  Q,
    input  logic             RCO,
    output logic [1:0]       STATE,
    output logic             ERR_Q,
    output logic             ERR_RCO,
    output logic             FAIL,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic [CNT_W-1:0] CHK_CNT
);

    typedef enum logic [1:0] {
        ST_UNSYNC = 2'b00,
        ST_TRACK  = 2'b01,
        ST_FAULT  = 2'b10
    } state_t;

    localparam logic [1:0]       c_MODO_UP   = 2'b00;
    localparam logic [1:0]       c_MODO_DOWN = 2'b01;
    localparam logic [1:0]       c_MODO_DN3  = 2'b10;
    localparam logic [BITS-1:0]  c_Q_ONE     = {{(BITS-1){1'b0}}, 1'b1};
    localparam logic [BITS-1:0]  c_Q_THREE   = {{(BITS-2){1'b0}}, 2'b11};
    localparam logic [CNT_W-1:0] c_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};

    state_t             r_state;
    logic [BITS-1:0]    r_exp_q;
    logic               r_exp_rco;
    logic               r_err_q;
    logic               r_err_rco;
    logic               r_fail;
    logic [CNT_W-1:0]   r_err_cnt;
    logic [CNT_W-1:0]   r_chk_cnt;

    state_t             w_state_nxt;
    logic [BITS-1:0]    w_exp_q_nxt;
    logic               w_exp_rco_nxt;
    logic               w_err_q_nxt;
    logic               w_err_rco_nxt;
    logic               w_fail_nxt;
    logic [CNT_W-1:0]   w_err_cnt_nxt;
    logic [CNT_W-1:0]   w_chk_cnt_nxt;

    logic [BITS-1:0]    w_model_q;
    logic               w_model_rco;
    logic               w_mis_q;
    logic               w_mis_rco;

    // Reference counter step, always advanced from the model, never from Q
    always_comb begin
        w_model_q   = r_exp_q;
        w_model_rco = r_exp_rco;
        if (ENB) begin
            case (MODO)
                c_MODO_UP:   begin w_model_q = r_exp_q + c_Q_ONE;   w_model_rco = 1'b0; end
                c_MODO_DOWN: begin w_model_q = r_exp_q - c_Q_ONE;   w_model_rco = 1'b0; end
                c_MODO_DN3:  begin w_model_q = r_exp_q - c_Q_THREE; w_model_rco = 1'b0; end
                default:     begin w_model_q = D;                   w_model_rco = 1'b1; end
            endcase
        end
    end

    assign w_mis_q   = (Q != r_exp_q);
    assign w_mis_rco = (RCO != r_exp_rco);

    // Next-state and next-output logic; error pulses default low every cycle
    always_comb begin
        w_state_nxt   = r_state;
        w_exp_q_nxt   = r_exp_q;
        w_exp_rco_nxt = r_exp_rco;
        w_err_q_nxt   = 1'b0;
        w_err_rco_nxt = 1'b0;
        w_fail_nxt    = r_fail;
        w_err_cnt_nxt = r_err_cnt;
        w_chk_cnt_nxt = r_chk_cnt;
        case (r_state)
            ST_UNSYNC: begin
                // Counter content is unknown until it is loaded
                if (ENB && (MODO == 2'b11)) begin
                    w_exp_q_nxt   = D;
                    w_exp_rco_nxt = 1'b1;
                    w_state_nxt   = ST_TRACK;
                end
            end
            ST_TRACK: begin
                w_chk_cnt_nxt = (r_chk_cnt == c_CNT_MAX) ? r_chk_cnt : r_chk_cnt + c_CNT_ONE;
                // Model advances even on a mismatch; FAULT makes it irrelevant
                w_exp_q_nxt   = w_model_q;
                w_exp_rco_nxt = w_model_rco;
                w_err_q_nxt   = w_mis_q;
                w_err_rco_nxt = w_mis_rco;
                if (w_mis_q || w_mis_rco) begin
                    w_err_cnt_nxt = (r_err_cnt == c_CNT_MAX) ? r_err_cnt : r_err_cnt + c_CNT_ONE;
                    w_fail_nxt    = 1'b1;
                    w_state_nxt   = ST_FAULT;
                end
            end
            ST_FAULT: begin
`ifdef CONTADOR_VERIF_RESYNC_EN
                w_state_nxt = ST_UNSYNC;
`else
                w_state_nxt = ST_FAULT;
`endif
            end
            default: begin
                w_state_nxt = ST_UNSYNC;
            end
        endcase
    end

    // State and result registers with asynchronous reset
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state   <= ST_UNSYNC;
            r_exp_q   <= '0;
            r_exp_rco <= 1'b0;
            r_err_q   <= 1'b0;
            r_err_rco <= 1'b0;
            r_fail    <= 1'b0;
            r_err_cnt <= '0;
            r_chk_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_exp_q   <= w_exp_q_nxt;
            r_exp_rco <= w_exp_rco_nxt;
            r_err_q   <= w_err_q_nxt;
            r_err_rco <= w_err_rco_nxt;
            r_fail    <= w_fail_nxt;
            r_err_cnt <= w_err_cnt_nxt;
            r_chk_cnt <= w_chk_cnt_nxt;
        end
    end

    assign STATE   = r_state;
    assign ERR_Q   = r_err_q;
    assign ERR_RCO = r_err_rco;
    assign FAIL    = r_fail;
    assign ERR_CNT = r_err_cnt;
    assign CHK_CNT = r_chk_cnt;

endmodule
`default_nettype wire

// File: tb/tb_contador_verificador.sv
`default_nettype none
// ============================================================================
// Module      : tb_contador_verificador
// Description : Directed bench for contador_verificador. A behavioural 4-bit
//               mode counter (no reset) produces Q/RCO, with override hooks to
//               inject wrong Q or RCO values. Expected checker outputs are
//               hand-computed constants.
// Option      : CONTADOR_VERIF_RESYNC_EN selects the resync expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_contador_verificador;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       ENB;
    logic [1:0] MODO;
    logic [3:0] D;
    logic [3:0] Q;
    logic       RCO;
    logic [1:0] STATE;
    logic       ERR_Q;
    logic       ERR_RCO;
    logic       FAIL;
    logic [7:0] ERR_CNT;
    logic [7:0] CHK_CNT;

    // Behavioural counter feeding the checker, plus fault-injection overrides
    logic [3:0] cnt_q   = 4'h7;
    logic       cnt_rco = 1'b0;
    logic       inj_q_en   = 1'b0;
    logic [3:0] inj_q      = 4'h0;
    logic       inj_rco_en = 1'b0;
    logic       inj_rco    = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    // Counter under observation: up, down, down-by-3, load with RCO
    always @(posedge CLK) begin
        if (ENB) begin
            case (MODO)
                2'b00:   begin cnt_q <= cnt_q + 4'h1; cnt_rco <= 1'b0; end
                2'b01:   begin cnt_q <= cnt_q - 4'h1; cnt_rco <= 1'b0; end
                2'b10:   begin cnt_q <= cnt_q - 4'h3; cnt_rco <= 1'b0; end
                default: begin cnt_q <= D;            cnt_rco <= 1'b1; end
            endcase
        end
    end

    assign Q   = inj_q_en   ? inj_q   : cnt_q;
    assign RCO = inj_rco_en ? inj_rco : cnt_rco;

    contador_verificador #(.BITS(4), .CNT_W(8)) u_dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .ENB     (ENB),
        .MODO    (MODO),
        .D       (D),
        .Q       (Q),
        .RCO     (RCO),
        .STATE   (STATE),
        .ERR_Q   (ERR_Q),
        .ERR_RCO (ERR_RCO),
        .FAIL    (FAIL),
        .ERR_CNT (ERR_CNT),
        .CHK_CNT (CHK_CNT)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st, input logic eq, input logic er,
                           input logic fl, input logic [7:0] ec, input logic [7:0] cc);
        chk({tag, ".STATE"},   {30'd0, STATE}, {30'd0, st});
        chk({tag, ".ERR_Q"},   {31'd0, ERR_Q}, {31'd0, eq});
        chk({tag, ".ERR_RCO"}, {31'd0, ERR_RCO}, {31'd0, er});
        chk({tag, ".FAIL"},    {31'd0, FAIL}, {31'd0, fl});
        chk({tag, ".ERR_CNT"}, {24'd0, ERR_CNT}, {24'd0, ec});
        chk({tag, ".CHK_CNT"}, {24'd0, CHK_CNT}, {24'd0, cc});
    endtask

    // Asynchronous reset pulse, checked before any clock edge
    task automatic do_reset(input string tag);
        RESET = 1'b1;
        #1;
        chk_all(tag, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        tick(1);
        RESET = 1'b0;
    endtask

    initial begin
        RESET = 1'b0; ENB = 1'b0; MODO = 2'b00; D = 4'h0;
        #2;
        do_reset("rst0");

        // UNSYNC: counting without a load never compares
        ENB = 1'b1; MODO = 2'b00;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk_all("unsync", 2'b00, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        end

        // Load A, count up through the wrap: A,B,C,D,E,F,0
        MODO = 2'b11; D = 4'hA;
        tick(1);
        chk("load_a.STATE", {30'd0, STATE}, 32'h1);
        chk("load_a.CHK_CNT", {24'd0, CHK_CNT}, 32'h0);
        MODO = 2'b00;
        for (int i = 0; i < 7; i++) begin
            tick(1);
            chk("up.ERR", {30'd0, ERR_Q, ERR_RCO}, 32'h0);
        end
        chk_all("up_done", 2'b01, 1'b0, 1'b0, 1'b0, 8'd0, 8'd7);

        // Load 2, down-by-3: 2,F,C,9, then inject 8 instead of 9
        MODO = 2'b11; D = 4'h2;
        tick(1);
        MODO = 2'b10;
        tick(3);
        chk_all("dn3_ok", 2'b01, 1'b0, 1'b0, 1'b0, 8'd0, 8'd11);
        ENB = 1'b0;
        inj_q_en = 1'b1; inj_q = 4'h8;
        tick(1);
        inj_q_en = 1'b0;
        chk_all("inj_q", 2'b10, 1'b1, 1'b0, 1'b1, 8'd1, 8'd12);
        tick(1);
`ifdef CONTADOR_VERIF_RESYNC_EN
        chk_all("inj_q_after", 2'b00, 1'b0, 1'b0, 1'b1, 8'd1, 8'd12);
`else
        chk_all("inj_q_after", 2'b10, 1'b0, 1'b0, 1'b1, 8'd1, 8'd12);
`endif

        // Fresh start: load 5, hold 3 cycles, then down 5 -> 4 -> 3
        do_reset("rst1");
        ENB = 1'b1; MODO = 2'b11; D = 4'h5;
        tick(1);
        ENB = 1'b0; MODO = 2'b01;
        tick(3);
        chk_all("hold", 2'b01, 1'b0, 1'b0, 1'b0, 8'd0, 8'd3);
        ENB = 1'b1;
        tick(1);
        chk_all("down1", 2'b01, 1'b0, 1'b0, 1'b0, 8'd0, 8'd4);
        // Counter now shows Q=4, RCO=0; force RCO high for this comparison
        inj_rco_en = 1'b1; inj_rco = 1'b1;
        tick(1);
        inj_rco_en = 1'b0;
        chk_all("inj_rco", 2'b10, 1'b0, 1'b1, 1'b1, 8'd1, 8'd5);

`ifdef CONTADOR_VERIF_RESYNC_EN
        ENB = 1'b0;
        tick(1);
        chk_all("resync", 2'b00, 1'b0, 1'b0, 1'b1, 8'd1, 8'd5);
        ENB = 1'b1; MODO = 2'b11; D = 4'h0;
        tick(1);
        chk_all("reload", 2'b01, 1'b0, 1'b0, 1'b1, 8'd1, 8'd5);
        ENB = 1'b0;
        inj_q_en = 1'b1; inj_q = 4'hF;
        tick(1);
        inj_q_en = 1'b0;
        chk_all("second_mis", 2'b10, 1'b1, 1'b0, 1'b1, 8'd2, 8'd6);
`else
        ENB = 1'b1; MODO = 2'b11; D = 4'h0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("terminal.STATE", {30'd0, STATE}, 32'h2);
        end
        chk_all("terminal", 2'b10, 1'b0, 1'b0, 1'b1, 8'd1, 8'd5);
`endif

        // Saturation of CHK_CNT over 300 matching cycles
        do_reset("rst2");
        ENB = 1'b1; MODO = 2'b11; D = 4'h3;
        tick(1);
        MODO = 2'b00;
        tick(254);
        chk_all("pre_sat", 2'b01, 1'b0, 1'b0, 1'b0, 8'd0, 8'd254);
        tick(46);
        chk_all("sat", 2'b01, 1'b0, 1'b0, 1'b0, 8'd0, 8'd255);

        // Reset mid-cycle clears everything without a clock edge
        #2;
        RESET = 1'b1;
        #1;
        chk_all("rst_async", 2'b00, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        tick(1);
        RESET = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/contador_verificador.md
Name: contador_verificador

Overview:
- Checker/monitor for the 4-bit mode counter (up, down, down-by-3, parallel load, registered RCO). It is the consuming end of the counter's interface.
- Sits in the bench/probe layer. It taps the stimulus the counter receives (ENB, MODO, D) and the counter's outputs (Q, RCO).
- Keeps a registered reference model, compares it every cycle, and reports mismatches, error counts and check counts.
- Synthesizable. It can also run on-chip as a built-in self-check.

Parameters:
- BITS, 4, width of D/Q and of the model register.
- CNT_W, 8, width of ERR_CNT and CHK_CNT.

Ports:
- CLK  input  1  clock; all sampling on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- ENB  input  1  enable seen by the counter.
- MODO  input  2  mode seen by the counter: 00 up, 01 down, 10 down-by-3, 11 load.
- D  input  BITS  load value seen by the counter.
- Q  input  BITS  counter output.
- RCO  input  1  counter RCO output.
- STATE  output  2  FSM state: 00 UNSYNC, 01 TRACK, 10 FAULT.
- ERR_Q  output  1  one-cycle pulse on Q mismatch.
- ERR_RCO  output  1  one-cycle pulse on RCO mismatch.
- FAIL  output  1  sticky failure flag.
- ERR_CNT  output  CNT_W  mismatching comparisons, saturating.
- CHK_CNT  output  CNT_W  comparisons performed, saturating.

Behaviour:
- Reset (asynchronous, active-high): STATE=UNSYNC, exp_q=0, exp_rco=0. ERR_Q, ERR_RCO, FAIL, ERR_CNT and CHK_CNT are all 0.
- Counter model, where an edge with ENB=1 is an enabled edge:
  - MODO 00: Q <= Q+1, RCO <= 0.
  - MODO 01: Q <= Q-1, RCO <= 0.
  - MODO 10: Q <= Q-3, RCO <= 0.
  - MODO 11: Q <= D, RCO <= 1.
  - ENB=0: Q and RCO hold.
  - All arithmetic is modulo 2^BITS: 0-1=F, 1-3=E, 2-3=F, F+1=0.
- Timing: the checker samples Q/RCO at edge k. These are the counter's results from edge k-1. ENB/MODO/D sampled at edge k drive the model update for edge k.
- UNSYNC: the counter has no reset, so no comparison is made here.
  - On an edge with ENB=1 and MODO=11: exp_q<=D, exp_rco<=1, STATE<=TRACK.
  - Otherwise stay in UNSYNC.
- TRACK, at every edge:
  - Compare Q against exp_q and RCO against exp_rco. CHK_CNT += 1, saturating at 2^CNT_W-1.
  - Q differs: ERR_Q=1 for the next cycle.
  - RCO differs: ERR_RCO=1 for the next cycle.
  - Either mismatch: ERR_CNT += 1 (once per edge, saturating), FAIL<=1, STATE<=FAULT.
  - Match: update exp from exp_q (never from observed Q) per the model using the sampled ENB/MODO/D. Stay in TRACK.
- Mismatch and load at the same edge: the mismatch wins and STATE goes to FAULT. The exp update still occurs but has no effect.
- FAULT: no comparisons; CHK_CNT and ERR_CNT hold; ERR_Q and ERR_RCO return to 0. Exit is governed by the optional feature.
- FAIL clears only on RESET.
- Reset mid-TRACK: everything returns to reset values immediately. Resynchronization requires a new load.
- Latency: mismatch at edge k gives the ERR pulses, FAIL and STATE=FAULT visible after edge k.

Optional Feature:
- CONTADOR_VERIF_RESYNC_EN defined: FAULT -> UNSYNC unconditionally at the next edge. Checking resumes after the next load. FAIL stays set and ERR_CNT keeps accumulating across resyncs.
- Not defined: FAULT is terminal until RESET.

Test Plan:
- Reset, then UNSYNC with ENB=1, MODO=00 for 5 cycles -> STATE=00, CHK_CNT=0, no ERR pulses.
- Load D=4'hA (MODO=11, ENB=1), then MODO=00 for 7 cycles -> Q sequence A,B,C,D,E,F,0; RCO=1 only in the cycle Q=A; CHK_CNT=7, ERR_CNT=0, FAIL=0.
- Load D=4'h2, then MODO=10 for 3 cycles -> expected Q sequence 2,F,C,9. Injecting Q=8 instead of 9 gives ERR_Q one cycle, ERR_CNT=1, FAIL=1, STATE=10.
- Load D=4'h5, MODO=01 with ENB=0 for 3 cycles, then ENB=1 for 2 cycles -> expected Q sequence 5,5,5,5,4,3 with no errors. RCO forced 1 while Q=4 gives ERR_RCO pulse with ERR_Q=0.
- With CONTADOR_VERIF_RESYNC_EN: mismatch -> STATE 10 then 00 next cycle; a load of D=4'h0 -> TRACK; a second mismatch -> ERR_CNT=2, FAIL still 1. Without the macro: STATE stays 10 for 20 cycles despite loads.
- Drive 300 matching cycles with CNT_W=8 -> CHK_CNT saturates at 255; assert RESET mid-run -> all outputs 0 and STATE=00 without waiting for a clock edge.
